// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   NIB_W   : width of the shared adder slice (one nibble)
//   state_e : controller FSM state encoding
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational NIB_W-bit ripple-carry adder slice.
// Ports:
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : nibble sum
//   cout : carry out of the top bit
module nibble_add_slice
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: adds two WIDTH-bit operands through one shared
// NIB_W-bit adder slice, LSB nibble first, carry registered between nibbles.
// Optional feature macro: NIBBLE_SERIAL_ADD_SUB_EN (adds op_sub, A - B mode).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : operation request handshake (accepted in IDLE)
//   op_a, op_b, carry_in     : operands and initial carry, sampled on accept
//   op_sub                   : (feature only) subtract, sampled on accept
//   res_valid/res_ready      : result handshake
//   res_sum, res_carry       : registered sum and final carry out
//   busy                     : high while running or holding a result
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             res_carry_q, res_carry_d;

    logic [NIB_W-1:0] a_nib, b_nib, slice_sum;
    logic             slice_cout;

    // Operand B and the initial carry are conditioned at accept time, so the
    // run loop is identical for add and subtract.
    logic [WIDTH-1:0] b_accept;
    logic             cin_accept;

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    assign b_accept   = op_sub ? ~op_b : op_b;
    assign cin_accept = op_sub ? 1'b1 : carry_in;
`else
    assign b_accept   = op_b;
    assign cin_accept = carry_in;
`endif

    // Select the current nibble of each operand.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_add_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        res_carry_d = res_carry_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = b_accept;
                    carry_d = cin_accept;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i*NIB_W +: NIB_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (cnt_q == LAST_CNT) begin
                    res_carry_d = slice_cout;
                    cnt_d       = '0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            res_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            res_carry_q <= res_carry_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign res_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign res_sum     = sum_q;
    assign res_carry   = res_carry_q;

endmodule
